cpu_top: RTL and testbench
==========================

Name: cpu_top

Overview:
- Top level of the processor: a single-cycle RV32I-subset core with no functional I/O beyond clock and reset.
- Contains:
  - the fetch stage, including instruction memory (instance fetch_unit);
  - decode, a 32x32 register file, ALU, branch logic and a small data memory.
- Programs are preloaded by hierarchical backdoor write into fetch_unit.instruction_memory while reset is asserted.
- Results are observed hierarchically.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words.
- DMEM_WORDS, 256, data memory depth in 32-bit words.
- RESET_PC, 32'h0000_0000, PC value on reset.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).

Behaviour:
- Reset (reset_n=0, asynchronous):
  - pc=RESET_PC, all regs=0, data memory=0.
  - instruction_memory is NOT cleared; contents written before or during reset persist.
- Hierarchy required for verification:
  - cpu_top.fetch_unit.instruction_memory[0:IMEM_WORDS-1], 32-bit, writable by the bench.
  - cpu_top.fetch_unit.pc, 32-bit.
  - cpu_top.regs[0:31], 32-bit.
  - cpu_top.dmem[0:DMEM_WORDS-1].
- Instruction encoding:
  - Word bit[31:0] is the RV32I encoding.
  - The loader places file byte 4i in bits[7:0] and byte 4i+3 in bits[31:24] (little-endian byte stream).
- Fetch:
  - Combinational read of instruction_memory[pc[9:2]].
  - Index wraps modulo IMEM_WORDS; pc[1:0] ignored.
- Single cycle per instruction: on each rising edge with reset_n=1, the instruction at pc retires and its register/memory writes occur on that edge.
- Next PC: pc+4 by default; branch or jump target when taken.
- Supported instructions:
  - R-type: ADD SUB AND OR XOR SLL SRL SRA SLT SLTU.
  - I-type ALU: ADDI ANDI ORI XORI SLTI SLTIU SLLI SRLI SRAI.
  - LUI, AUIPC.
  - JAL, JALR (target LSB cleared).
  - BEQ BNE BLT BGE BLTU BGEU.
  - LW, SW: word only; address bits[9:2], wrap modulo DMEM_WORDS.
- Immediates are sign-extended per RV32I.
- Arithmetic is 32-bit wraparound, no exceptions.
- Shift amount uses the low 5 bits.
- x0 always reads 0; writes to x0 are discarded.
- Any unsupported opcode or funct encoding is a NOP: pc+4, no state change.
- Reads use the pre-edge register values; a destination equal to a source still reads the old value within that cycle.
- Reset asserted mid-run: immediate return to reset state; execution restarts from RESET_PC on the first rising edge after release.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE);
  - funct3/funct7 constants;
  - the ALU-op enum.
- One sub-module, fetch_unit, instance name fetch_unit:
  - holds pc and instruction_memory;
  - outputs the instruction;
  - accepts next_pc.
- Decode, ALU, register file and data memory stay in cpu_top.

Test Plan:
- Reset hold: load program, keep reset_n=0 for 3 edges -> pc=0, all regs 0, program intact.
- ALU sequence: ADDI x1,x0,5; ADDI x2,x0,7; ADD x3,x1,x2 -> after 3 edges x1=5, x2=7, x3=12, pc=12.
- x0 and SUB:
  - ADDI x0,x0,9 -> x0 stays 0.
  - Then ADDI x1,x0,3; SUB x2,x0,x1 -> x2=32'hFFFF_FFFD.
- Branch/jump:
  - ADDI x1,x0,1; BEQ x1,x1,+8 -> the skipped instruction has no effect, pc=12.
  - JAL x5,-12 -> x5=pc+4, pc returns to 0.
- Memory: ADDI x1,x0,42; SW x1,8(x0); LW x2,8(x0) -> dmem[2]=42, x2=42.
- Async reset mid-run: drop reset_n between edges after 2 instructions -> pc and regs zero immediately (no clock edge); after release, re-executes from address 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings and types for the single-cycle RV32I-subset core.
package cpu_pkg;

  // Major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Memory / jump funct3
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  // funct7
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor,
    AluSll, AluSrl, AluSra, AluSlt, AluSltu
  } alu_op_e;

  typedef enum logic [1:0] {WbAlu, WbPc4, WbMem} wb_sel_e;

  function automatic logic [31:0] alu_compute(input alu_op_e op, input logic [31:0] a,
                                              input logic [31:0] b);
    logic [31:0] r;
    case (op)
      AluAdd:  r = a + b;
      AluSub:  r = a - b;
      AluAnd:  r = a & b;
      AluOr:   r = a | b;
      AluXor:  r = a ^ b;
      AluSll:  r = a << b[4:0];
      AluSrl:  r = a >> b[4:0];
      AluSra:  r = 32'($signed(a) >>> b[4:0]);
      AluSlt:  r = {31'b0, $signed(a) < $signed(b)};
      AluSltu: r = {31'b0, a < b};
      default: r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_top_fetch_unit.sv
// Fetch stage: program counter and instruction memory with combinational read.
module cpu_top_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  localparam int unsigned ImemAw    = $clog2(IMEM_WORDS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       next_pc_i,
  input  logic              imem_we_i,
  input  logic [ImemAw-1:0] imem_waddr_i,
  input  logic [31:0]       imem_wdata_i,
  output logic [31:0]       pc_o,
  output logic [31:0]       instr_o
);

  logic [31:0] pc;
  logic [31:0] instruction_memory [0:IMEM_WORDS-1];

  // PC register; returns to RESET_PC immediately on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc_i;
    end
  end

  // Instruction memory write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (imem_we_i) begin
      instruction_memory[imem_waddr_i] <= imem_wdata_i;
    end
  end

  // Word index wraps modulo depth; byte offset bits ignored
  always_comb begin
    pc_o    = pc;
    instr_o = instruction_memory[pc[ImemAw+1:2]];
  end

endmodule

// File: rtl/cpu_top.sv
// Single-cycle RV32I-subset core: decode, register file, ALU, branches, data memory.
module cpu_top
  import cpu_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic reset_n
);

  localparam int unsigned ImemAw = $clog2(IMEM_WORDS);
  localparam int unsigned DmemAw = $clog2(DMEM_WORDS);

  logic [31:0] regs [0:31];
  logic [31:0] dmem [0:DMEM_WORDS-1];

  logic [31:0] pc, instr, next_pc, pc_plus4;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, alu_a, alu_b, alu_result, rd_wdata;
  logic [DmemAw-1:0] dmem_idx;
  alu_op_e     alu_op;
  wb_sel_e     wb_sel;
  logic        rd_we, mem_we, is_branch, is_jal, is_jalr, branch_taken;

  // The loader port is idle; programs are preloaded hierarchically
  cpu_top_fetch_unit #(
    .IMEM_WORDS (IMEM_WORDS),
    .RESET_PC   (RESET_PC)
  ) fetch_unit (
    .clk          (clk),
    .reset_n      (reset_n),
    .next_pc_i    (next_pc),
    .imem_we_i    (1'b0),
    .imem_waddr_i ({ImemAw{1'b0}}),
    .imem_wdata_i (32'h0),
    .pc_o         (pc),
    .instr_o      (instr)
  );

  // Field extraction, immediates and operand reads (x0 is held at zero)
  always_comb begin
    opcode   = instr[6:0];
    rd       = instr[11:7];
    funct3   = instr[14:12];
    rs1      = instr[19:15];
    rs2      = instr[24:20];
    funct7   = instr[31:25];
    imm_i    = {{20{instr[31]}}, instr[31:20]};
    imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_u    = {instr[31:12], 12'b0};
    imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    rs1_val  = regs[rs1];
    rs2_val  = regs[rs2];
    pc_plus4 = pc + 32'd4;
  end

  // Decode; anything unrecognised leaves all enables low and so acts as a NOP
  always_comb begin
    alu_op    = AluAdd;
    alu_a     = rs1_val;
    alu_b     = rs2_val;
    wb_sel    = WbAlu;
    rd_we     = 1'b0;
    mem_we    = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OP_R: begin
        rd_we = 1'b1;
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD:  alu_op = AluAdd;
            F3_SLL:  alu_op = AluSll;
            F3_SLT:  alu_op = AluSlt;
            F3_SLTU: alu_op = AluSltu;
            F3_XOR:  alu_op = AluXor;
            F3_SR:   alu_op = AluSrl;
            F3_OR:   alu_op = AluOr;
            default: alu_op = AluAnd;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          alu_op = AluSub;
        end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
          alu_op = AluSra;
        end else begin
          rd_we = 1'b0;
        end
      end
      OP_IMM: begin
        rd_we = 1'b1;
        alu_b = imm_i;
        case (funct3)
          F3_ADD:  alu_op = AluAdd;
          F3_SLT:  alu_op = AluSlt;
          F3_SLTU: alu_op = AluSltu;
          F3_XOR:  alu_op = AluXor;
          F3_OR:   alu_op = AluOr;
          F3_AND:  alu_op = AluAnd;
          F3_SLL: begin
            alu_op = AluSll;
            rd_we  = (funct7 == F7_BASE);
          end
          default: begin
            alu_op = (funct7 == F7_ALT) ? AluSra : AluSrl;
            rd_we  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
        endcase
      end
      OP_LUI: begin
        rd_we = 1'b1;
        alu_a = 32'h0;
        alu_b = imm_u;
      end
      OP_AUIPC: begin
        rd_we = 1'b1;
        alu_a = pc;
        alu_b = imm_u;
      end
      OP_JAL: begin
        rd_we  = 1'b1;
        wb_sel = WbPc4;
        is_jal = 1'b1;
      end
      OP_JALR: begin
        if (funct3 == F3_JALR) begin
          rd_we   = 1'b1;
          wb_sel  = WbPc4;
          is_jalr = 1'b1;
          alu_b   = imm_i;
        end
      end
      OP_BRANCH: is_branch = (funct3 != 3'b010) && (funct3 != 3'b011);
      OP_LOAD: begin
        if (funct3 == F3_LW) begin
          rd_we  = 1'b1;
          alu_b  = imm_i;
          wb_sel = WbMem;
        end
      end
      OP_STORE: begin
        if (funct3 == F3_SW) begin
          mem_we = 1'b1;
          alu_b  = imm_s;
        end
      end
      default: ;
    endcase
  end

  assign alu_result = alu_compute(alu_op, alu_a, alu_b);
  assign dmem_idx   = alu_result[DmemAw+1:2];

  // Branch condition, writeback mux and next-PC selection
  always_comb begin
    case (funct3)
      F3_BEQ:  branch_taken = (rs1_val == rs2_val);
      F3_BNE:  branch_taken = (rs1_val != rs2_val);
      F3_BLT:  branch_taken = ($signed(rs1_val) < $signed(rs2_val));
      F3_BGE:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: branch_taken = (rs1_val < rs2_val);
      F3_BGEU: branch_taken = (rs1_val >= rs2_val);
      default: branch_taken = 1'b0;
    endcase

    case (wb_sel)
      WbPc4:   rd_wdata = pc_plus4;
      WbMem:   rd_wdata = dmem[dmem_idx];
      default: rd_wdata = alu_result;
    endcase

    next_pc = pc_plus4;
    if (is_jal) begin
      next_pc = pc + imm_j;
    end else if (is_jalr) begin
      next_pc = {alu_result[31:1], 1'b0};
    end else if (is_branch && branch_taken) begin
      next_pc = pc + imm_b;
    end
  end

  // Register file write; x0 writes are dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (rd_we && (rd != 5'd0)) begin
      regs[rd] <= rd_wdata;
    end
  end

  // Data memory write; cleared on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        dmem[i] <= 32'h0;
      end
    end else if (mem_we) begin
      dmem[dmem_idx] <= rs2_val;
    end
  end

endmodule

// File: tb/tb_cpu_top.sv
// Directed-program bench for cpu_top with hand-computed architectural results.
module tb_cpu_top;

  logic clk;
  logic reset_n;

  int n_cmp;
  int n_bad;

  cpu_top dut (
    .clk     (clk),
    .reset_n (reset_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_lw(input int imm, input int rs1, input int rd);
    return {imm[11:0], rs1[4:0], 3'b010, rd[4:0], 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                        input int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_u(input int imm, input int rd, input int op);
    return {imm[19:0], rd[4:0], op[6:0]};
  endfunction

  // Assert reset and fill program memory with ADDI x0,x0,0
  task automatic enter_reset();
    @(negedge clk);
    reset_n = 1'b0;
    for (int i = 0; i < 256; i++) begin
      dut.fetch_unit.instruction_memory[i] = 32'h0000_0013;
    end
  endtask

  task automatic put(input int idx, input logic [31:0] w);
    dut.fetch_unit.instruction_memory[idx] = w;
  endtask

  task automatic leave_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_alu_prog();
    put(0, enc_i(5, 0, 0, 1));
    put(1, enc_i(7, 0, 0, 2));
    put(2, enc_r(0, 2, 1, 0, 3));
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;

    // Reset hold: edges under reset must not execute
    enter_reset();
    load_alu_prog();
    step(3);
    check("hold_pc", dut.fetch_unit.pc, 32'h0);
    check("hold_x1", dut.regs[1], 32'h0);
    check("hold_x3", dut.regs[3], 32'h0);
    check("hold_imem0", dut.fetch_unit.instruction_memory[0], 32'h0050_0093);
    check("hold_imem2", dut.fetch_unit.instruction_memory[2], 32'h0020_81B3);

    // ALU sequence
    leave_reset();
    step(3);
    check("alu_x1", dut.regs[1], 32'd5);
    check("alu_x2", dut.regs[2], 32'd7);
    check("alu_x3", dut.regs[3], 32'd12);
    check("alu_pc", dut.fetch_unit.pc, 32'd12);

    // x0 is immutable; SUB wraps
    enter_reset();
    put(0, enc_i(9, 0, 0, 0));
    put(1, enc_i(3, 0, 0, 1));
    put(2, enc_r(32, 1, 0, 0, 2));
    leave_reset();
    step(3);
    check("x0_zero", dut.regs[0], 32'h0);
    check("sub_x1", dut.regs[1], 32'd3);
    check("sub_x2", dut.regs[2], 32'hFFFF_FFFD);

    // Taken branch skips one instruction, JAL back to 0
    enter_reset();
    put(0, enc_i(1, 0, 0, 1));
    put(1, enc_b(8, 1, 1, 0));
    put(2, enc_i(99, 0, 0, 3));
    put(3, enc_j(-12, 5));
    leave_reset();
    step(2);
    check("beq_pc", dut.fetch_unit.pc, 32'd12);
    check("beq_x1", dut.regs[1], 32'd1);
    step(1);
    check("jal_x5", dut.regs[5], 32'd16);
    check("jal_pc", dut.fetch_unit.pc, 32'd0);
    check("skip_x3", dut.regs[3], 32'd0);

    // Store then load
    enter_reset();
    put(0, enc_i(42, 0, 0, 1));
    put(1, enc_s(8, 1, 0));
    put(2, enc_lw(8, 0, 2));
    leave_reset();
    step(3);
    check("sw_dmem2", dut.dmem[2], 32'd42);
    check("lw_x2", dut.regs[2], 32'd42);
    check("mem_pc", dut.fetch_unit.pc, 32'd12);

    // Shifts, compares, LUI/AUIPC, untaken BNE, unsupported funct7 (MUL)
    enter_reset();
    put(0, enc_u(32'h80000, 1, 7'b0110111));
    put(1, enc_i(32'h404, 1, 5, 2));
    put(2, enc_i(4, 1, 5, 3));
    put(3, enc_r(0, 1, 0, 3, 4));
    put(4, enc_r(0, 0, 1, 2, 5));
    put(5, enc_i(-1, 1, 4, 6));
    put(6, enc_b(8, 0, 0, 1));
    put(7, enc_u(1, 7, 7'b0010111));
    put(8, enc_r(1, 1, 1, 0, 8));
    leave_reset();
    step(9);
    check("lui_x1", dut.regs[1], 32'h8000_0000);
    check("srai_x2", dut.regs[2], 32'hF800_0000);
    check("srli_x3", dut.regs[3], 32'h0800_0000);
    check("sltu_x4", dut.regs[4], 32'd1);
    check("slt_x5", dut.regs[5], 32'd1);
    check("xori_x6", dut.regs[6], 32'h7FFF_FFFF);
    check("auipc_x7", dut.regs[7], 32'h0000_101C);
    check("nop_x8", dut.regs[8], 32'h0);
    check("misc_pc", dut.fetch_unit.pc, 32'd36);

    // Asynchronous reset between edges, then re-execution from 0
    enter_reset();
    load_alu_prog();
    leave_reset();
    step(2);
    check("pre_x2", dut.regs[2], 32'd7);
    #2 reset_n = 1'b0;
    #1;
    check("async_pc", dut.fetch_unit.pc, 32'h0);
    check("async_x1", dut.regs[1], 32'h0);
    check("async_x2", dut.regs[2], 32'h0);
    leave_reset();
    step(1);
    check("rerun_pc", dut.fetch_unit.pc, 32'd4);
    check("rerun_x1", dut.regs[1], 32'd5);
    check("rerun_x2", dut.regs[2], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
